cbus_chan: RTL and testbench

CBUS_CHAN -- requirements
Module: cbus_chan

---
 rtl/cbus_chan.sv | 130 +++++++++++++
 tb/tb_cbus_chan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cbus_chan.sv
// Channel-side CBUS endpoint: moves a block of 36-bit words between a device
// port and the MBOX through a shared 4-deep FIFO, in either direction.
//
// state | meaning
// IDLE  | waiting for CH_START
// XFER  | moving words; remaining counter counts granted CBUS slots
// DRAIN | read direction: all words fetched, device still emptying the FIFO
// DONE  | one-cycle completion pulse
module cbus_chan (
   input  logic        clk,
   input  logic        CROBAR,
   input  logic        CH_START,
   input  logic        CH_DIR,
   input  logic [3:0]  CH_WC,
   input  logic        CH_REVERSE,
   input  logic [35:0] CH_WR_DATA,
   input  logic        CH_WR_VALID,
   output logic        CH_WR_READY,
   output logic [35:0] CH_RD_DATA,
   output logic        CH_RD_VALID,
   input  logic        CH_RD_READY,
   output logic        CBUS_REQ,
   input  logic        CBUS_ACK,
   output logic [35:0] CBUS_D_RE,
   input  logic [35:0] CBUS_D_TE,
   input  logic        CBUS_ERR,
   output logic        CH_BUSY,
   output logic        CH_DONE,
   output logic        CH_ERR
);

   typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_DONE} state_t;

   state_t      r_state, w_state_nxt;
   logic [35:0] r_mem [4];
   logic [1:0]  r_wp, r_rp;
   logic [2:0]  r_occ, w_occ_nxt;
   logic [4:0]  r_rem;
   logic        r_dir, r_rev, r_err;

   logic        w_xfer, w_act, w_full, w_empty;
   logic        w_wr_ready, w_req, w_ack, w_rd_valid;
   logic        w_push, w_pop, w_abort;
   logic [35:0] w_head, w_te_sw, w_push_data;

   assign w_xfer     = (r_state == ST_XFER);
   assign w_act      = w_xfer | (r_state == ST_DRAIN);
   assign w_full     = (r_occ == 3'd4);
   assign w_empty    = (r_occ == 3'd0);
   assign w_head     = r_mem[r_rp];
   assign w_te_sw    = r_rev ? {CBUS_D_TE[17:0], CBUS_D_TE[35:18]} : CBUS_D_TE;

   // Write side never counts on a same-cycle pop: only words still owed are accepted.
   assign w_wr_ready = w_xfer & r_dir & ~w_full & (r_rem > {2'b00, r_occ});
   assign w_req      = w_xfer & (r_dir ? ~w_empty : ((r_rem != 5'd0) & ~w_full));
   assign w_ack      = w_req & CBUS_ACK;
   assign w_rd_valid = w_act & ~r_dir & ~w_empty;
   assign w_push     = r_dir ? (w_wr_ready & CH_WR_VALID) : w_ack;
   assign w_pop      = r_dir ? w_ack : (w_rd_valid & CH_RD_READY);
   assign w_push_data = r_dir ? CH_WR_DATA : w_te_sw;
   assign w_abort    = w_act & CBUS_ERR;
   assign w_occ_nxt  = r_occ + {2'b00, w_push} - {2'b00, w_pop};

   always_ff @(posedge clk) begin
      if (CROBAR) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (CH_START) w_state_nxt = ST_XFER;
         ST_XFER: begin
            if (w_abort)                          w_state_nxt = ST_DONE;
            else if (w_ack && r_rem == 5'd1)      w_state_nxt = r_dir ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_abort || w_occ_nxt == 3'd0)     w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      CH_BUSY     = w_act;
      CH_DONE     = (r_state == ST_DONE);
      CH_ERR      = r_err;
      CBUS_REQ    = w_req;
      CH_WR_READY = w_wr_ready;
      CH_RD_VALID = w_rd_valid;
      CH_RD_DATA  = w_rd_valid ? w_head : 36'd0;
      CBUS_D_RE   = 36'd0;
      if (w_req && r_dir)
         CBUS_D_RE = r_rev ? {w_head[17:0], w_head[35:18]} : w_head;
   end

   always_ff @(posedge clk) begin
      if (CROBAR) begin
         r_occ <= 3'd0;
         r_wp  <= 2'd0;
         r_rp  <= 2'd0;
         r_rem <= 5'd0;
         r_dir <= 1'b0;
         r_rev <= 1'b0;
         r_err <= 1'b0;
      end else if (r_state == ST_IDLE && CH_START) begin
         r_rem <= (CH_WC == 4'd0) ? 5'd16 : {1'b0, CH_WC};
         r_dir <= CH_DIR;
         r_rev <= CH_REVERSE;
         r_err <= 1'b0;
      end else if (w_abort) begin
         r_err <= 1'b1;
         r_occ <= 3'd0;
         r_wp  <= 2'd0;
         r_rp  <= 2'd0;
         r_rem <= 5'd0;
      end else begin
         if (w_push) r_wp  <= r_wp + 2'd1;
         if (w_pop)  r_rp  <= r_rp + 2'd1;
         if (w_ack)  r_rem <= r_rem - 5'd1;
         r_occ <= w_occ_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!CROBAR && w_push && !w_abort) r_mem[r_wp] <= w_push_data;
   end

endmodule

// File: tb/tb_cbus_chan.sv
// Directed bench for cbus_chan: write, reversed read, backpressure,
// error abort and mid-transfer reset, with hand-computed expectations.
module tb_cbus_chan;
   logic        clk = 1'b0;
   logic        CROBAR = 1'b1;
   logic        CH_START = 1'b0, CH_DIR = 1'b0, CH_REVERSE = 1'b0;
   logic [3:0]  CH_WC = 4'd0;
   logic [35:0] CH_WR_DATA = 36'd0;
   logic        CH_WR_VALID = 1'b0, CH_WR_READY;
   logic [35:0] CH_RD_DATA;
   logic        CH_RD_VALID, CH_RD_READY = 1'b0;
   logic        CBUS_REQ, CBUS_ACK = 1'b0, CBUS_ERR = 1'b0;
   logic [35:0] CBUS_D_RE, CBUS_D_TE = 36'd0;
   logic        CH_BUSY, CH_DONE, CH_ERR;

   int n_chk = 0;
   int n_err = 0;

   cbus_chan dut (
      .clk(clk), .CROBAR(CROBAR), .CH_START(CH_START), .CH_DIR(CH_DIR),
      .CH_WC(CH_WC), .CH_REVERSE(CH_REVERSE), .CH_WR_DATA(CH_WR_DATA),
      .CH_WR_VALID(CH_WR_VALID), .CH_WR_READY(CH_WR_READY),
      .CH_RD_DATA(CH_RD_DATA), .CH_RD_VALID(CH_RD_VALID), .CH_RD_READY(CH_RD_READY),
      .CBUS_REQ(CBUS_REQ), .CBUS_ACK(CBUS_ACK), .CBUS_D_RE(CBUS_D_RE),
      .CBUS_D_TE(CBUS_D_TE), .CBUS_ERR(CBUS_ERR), .CH_BUSY(CH_BUSY),
      .CH_DONE(CH_DONE), .CH_ERR(CH_ERR)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_req"},   {35'd0, CBUS_REQ},    36'd0);
      chk({tag, "_wrrdy"}, {35'd0, CH_WR_READY}, 36'd0);
      chk({tag, "_rdval"}, {35'd0, CH_RD_VALID}, 36'd0);
      chk({tag, "_busy"},  {35'd0, CH_BUSY},     36'd0);
      chk({tag, "_done"},  {35'd0, CH_DONE},     36'd0);
      chk({tag, "_err"},   {35'd0, CH_ERR},      36'd0);
      chk({tag, "_dre"},   CBUS_D_RE,            36'd0);
      chk({tag, "_rddat"}, CH_RD_DATA,           36'd0);
   endtask

   int  n_sent, n_recv;
   bit  seen_done, seen_drain;

   initial begin
      // reset
      repeat (2) @(negedge clk);
      chk_quiet("rst");
      CROBAR = 1'b0;
      @(negedge clk);

      // write of 3 words, ACK held
      CH_START = 1; CH_DIR = 1; CH_WC = 4'd3; CH_REVERSE = 0; CBUS_ACK = 1;
      @(negedge clk);
      CH_START = 0;
      chk("t1_busy", {35'd0, CH_BUSY}, 36'd1);
      chk("t1_req0", {35'd0, CBUS_REQ}, 36'd0);
      chk("t1_rdy0", {35'd0, CH_WR_READY}, 36'd1);
      CH_WR_DATA = 36'd1; CH_WR_VALID = 1;
      @(negedge clk);
      chk("t1_dre1", CBUS_D_RE, 36'd1);
      CH_WR_DATA = 36'd2;
      @(negedge clk);
      chk("t1_dre2", CBUS_D_RE, 36'd2);
      CH_WR_DATA = 36'd3;
      @(negedge clk);
      chk("t1_dre3", CBUS_D_RE, 36'd3);
      chk("t1_rdy_last", {35'd0, CH_WR_READY}, 36'd0);
      CH_WR_VALID = 0;
      @(negedge clk);
      chk("t1_done", {35'd0, CH_DONE}, 36'd1);
      chk("t1_busy_off", {35'd0, CH_BUSY}, 36'd0);
      @(negedge clk);
      chk("t1_done_once", {35'd0, CH_DONE}, 36'd0);
      CBUS_ACK = 0;

      // read with reverse
      CH_START = 1; CH_DIR = 0; CH_WC = 4'd2; CH_REVERSE = 1; CBUS_ACK = 1; CH_RD_READY = 1;
      CBUS_D_TE = 36'o000001_000002;
      @(negedge clk);
      CH_START = 0; CH_REVERSE = 0;
      chk("t2_req", {35'd0, CBUS_REQ}, 36'd1);
      chk("t2_val0", {35'd0, CH_RD_VALID}, 36'd0);
      @(negedge clk);
      chk("t2_val1", {35'd0, CH_RD_VALID}, 36'd1);
      chk("t2_dat1", CH_RD_DATA, 36'o000002_000001);
      CBUS_D_TE = 36'o000003_000004;
      @(negedge clk);
      chk("t2_dat2", CH_RD_DATA, 36'o000004_000003);
      chk("t2_drain_req", {35'd0, CBUS_REQ}, 36'd0);
      chk("t2_drain_busy", {35'd0, CH_BUSY}, 36'd1);
      @(negedge clk);
      chk("t2_done", {35'd0, CH_DONE}, 36'd1);
      @(negedge clk);

      // read backpressure, 16 words
      CH_START = 1; CH_DIR = 0; CH_WC = 4'd0; CBUS_ACK = 1; CH_RD_READY = 0;
      @(negedge clk);
      CH_START = 0;
      n_sent = 0; n_recv = 0; seen_done = 0; seen_drain = 0;
      for (int cyc = 0; cyc < 120 && !seen_done; cyc++) begin
         if (cyc == 8) CH_RD_READY = 1;
         if (cyc == 6) chk("t3_req_full", {35'd0, CBUS_REQ}, 36'd0);
         if (cyc == 7) chk("t3_acks_full", 36'(n_sent), 36'd4);
         CBUS_D_TE = 36'(n_sent + 1);
         if (CBUS_REQ) n_sent++;
         if (CH_RD_VALID && CH_RD_READY) begin
            chk("t3_data", CH_RD_DATA, 36'(n_recv + 1));
            n_recv++;
         end
         if (CH_BUSY && !CBUS_REQ && n_sent == 16) seen_drain = 1;
         if (CH_DONE) seen_done = 1;
         @(negedge clk);
      end
      chk("t3_done_seen", {35'd0, seen_done}, 36'd1);
      chk("t3_sent", 36'(n_sent), 36'd16);
      chk("t3_recv", 36'(n_recv), 36'd16);
      chk("t3_drain_seen", {35'd0, seen_drain}, 36'd1);
      CBUS_ACK = 0; CH_RD_READY = 0;
      @(negedge clk);

      // error abort on 2nd ACK of an 8-word write
      CH_START = 1; CH_DIR = 1; CH_WC = 4'd8; CBUS_ACK = 1;
      CH_WR_VALID = 1; CH_WR_DATA = 36'h11;
      @(negedge clk);
      CH_START = 0;
      @(negedge clk);
      chk("t4_dre1", CBUS_D_RE, 36'h11);
      CH_WR_DATA = 36'h22;
      @(negedge clk);
      chk("t4_dre2", CBUS_D_RE, 36'h22);
      CH_WR_DATA = 36'h33; CBUS_ERR = 1;
      @(negedge clk);
      CBUS_ERR = 0; CH_WR_VALID = 0; CBUS_ACK = 0;
      chk("t4_done", {35'd0, CH_DONE}, 36'd1);
      chk("t4_err", {35'd0, CH_ERR}, 36'd1);
      chk("t4_busy", {35'd0, CH_BUSY}, 36'd0);
      chk("t4_req", {35'd0, CBUS_REQ}, 36'd0);
      repeat (4) @(negedge clk);
      chk("t4_err_sticky", {35'd0, CH_ERR}, 36'd1);
      chk("t4_idle_done", {35'd0, CH_DONE}, 36'd0);
      CH_START = 1; CH_DIR = 0; CH_WC = 4'd1; CH_RD_READY = 1;
      @(negedge clk);
      CH_START = 0;
      chk("t4_err_clr", {35'd0, CH_ERR}, 36'd0);
      chk("t4_flushed", {35'd0, CH_RD_VALID}, 36'd0);
      chk("t4_rd_req", {35'd0, CBUS_REQ}, 36'd1);
      CBUS_ACK = 1; CBUS_D_TE = 36'h5;
      @(negedge clk);
      CBUS_ACK = 0;
      chk("t4_rd_dat", CH_RD_DATA, 36'h5);
      chk("t4_rd_noreq", {35'd0, CBUS_REQ}, 36'd0);
      @(negedge clk);
      chk("t4_rd_done", {35'd0, CH_DONE}, 36'd1);
      CH_RD_READY = 0;
      @(negedge clk);

      // ignored restart and reset mid-XFER with two words queued
      CH_START = 1; CH_DIR = 1; CH_WC = 4'd8; CBUS_ACK = 0;
      CH_WR_VALID = 1; CH_WR_DATA = 36'haa;
      @(negedge clk);
      CH_DIR = 0; CH_WC = 4'd1;
      @(negedge clk);
      CH_START = 0; CH_DIR = 1; CH_WR_DATA = 36'hbb;
      @(negedge clk);
      CH_WR_VALID = 0;
      chk("t5_req", {35'd0, CBUS_REQ}, 36'd1);
      chk("t5_dre", CBUS_D_RE, 36'haa);
      chk("t5_no_reload", {35'd0, CH_WR_READY}, 36'd1);
      CROBAR = 1;
      @(negedge clk);
      chk_quiet("t5_rst");
      CROBAR = 0;
      @(negedge clk);
      chk("t5_no_done", {35'd0, CH_DONE}, 36'd0);
      chk("t5_idle", {35'd0, CH_BUSY}, 36'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
